wb_pad_ctrl: RTL and testbench

- Wishbone-slave pad controller between the user-project Wishbone port and a parametrised group of GPIO pads.
- Provides per-pad output data and output-enable registers, and 2-flop synchronised input sampling.
- Per-pad rising/falling edge detection drives sticky pending bits, which feed the user IRQ lines.
- Successor to the fixed, hard-wired pad slice: pad count and address window are parameters, and pad direction is run-time programmable.

---
 rtl/wb_pad_ctrl_if.sv | 22 ++
 rtl/wb_pad_ctrl.sv | 147 ++++++++++++++
 tb/tb_wb_pad_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pad_ctrl_if.sv
// Wishbone slave bus bundle for the pad controller.
// Signal names keep the user-project port naming so the two sides line up one-to-one.
interface wb_pad_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_pad_ctrl.sv
// Wishbone pad controller: output/OE registers, synchronised inputs, and
// edge-detect sticky pending bits driving the user IRQ lines.
module wb_pad_ctrl #(
  parameter int               NPADS     = 16,
  parameter logic [31:0]      ADDR_BASE = 32'h3000_0000,
  parameter logic [NPADS-1:0] OEB_RESET = '1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  wb_pad_ctrl_if.slave     wbs,
  input  logic [NPADS-1:0] io_in,
  output logic [NPADS-1:0] io_out,
  output logic [NPADS-1:0] io_oeb,
  output logic [2:0]       irq
);

  logic [NPADS-1:0] out_reg, oeb_reg, rise_en_reg, fall_en_reg, rise_pend_reg, fall_pend_reg;
  logic [NPADS-1:0] out_next, oeb_next, rise_en_next, fall_en_next, rise_pend_next, fall_pend_next;
  logic             err_reg, err_next;
  logic [NPADS-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [NPADS-1:0] rise_edge, fall_edge;
  logic             ack_reg;
  logic [31:0]      dat_reg, dat_next;
  logic [2:0]       irq_reg, irq_next;

  logic             sel_hit, mapped, wr_en;
  logic [7:0]       offset;
  logic [2:0]       idx;
  logic [31:0]      byte_mask, rd_data;
  logic [NPADS-1:0] wmask, wdata;
  logic             unused_hi;

  genvar gi;

  assign offset  = wbs.wbs_adr_i[7:0];
  assign idx     = offset[4:2];
  assign sel_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_reg
                 & (wbs.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  // Only word-aligned offsets 0x00..0x1C are registers; anything else flags ERR.
  assign mapped  = (offset[1:0] == 2'b00) && (offset[7:5] == 3'b000);
  assign wr_en   = sel_hit & wbs.wbs_we_i & mapped;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_mask[8*gi +: 8] = {8{wbs.wbs_sel_i[gi]}};
    end
  endgenerate

  assign wmask     = byte_mask[NPADS-1:0];
  assign wdata     = wbs.wbs_dat_i[NPADS-1:0] & wmask;
  assign unused_hi = ^{wbs.wbs_dat_i, byte_mask};

  generate
    for (gi = 0; gi < NPADS; gi++) begin : g_pad
      assign rise_edge[gi] =  sync2_reg[gi] & ~prev_reg[gi];
      assign fall_edge[gi] = ~sync2_reg[gi] &  prev_reg[gi];
    end
  endgenerate

  function automatic logic [31:0] widen(input logic [NPADS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NPADS-1:0] = v;
    return r;
  endfunction

  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0: rd_data = widen(out_reg);
      3'd1: rd_data = widen(oeb_reg);
      3'd2: rd_data = widen(sync2_reg);
      3'd3: rd_data = widen(rise_en_reg);
      3'd4: rd_data = widen(fall_en_reg);
      3'd5: rd_data = widen(rise_pend_reg);
      3'd6: rd_data = widen(fall_pend_reg);
      3'd7: rd_data = {31'b0, err_reg};
    endcase
  end

  always_comb begin
    out_next       = out_reg;
    oeb_next       = oeb_reg;
    rise_en_next   = rise_en_reg;
    fall_en_next   = fall_en_reg;
    rise_pend_next = rise_pend_reg;
    fall_pend_next = fall_pend_reg;
    err_next       = err_reg;
    if (wr_en) begin
      case (idx)
        3'd0: out_next       = (out_reg & ~wmask) | wdata;
        3'd1: oeb_next       = (oeb_reg & ~wmask) | wdata;
        3'd3: rise_en_next   = (rise_en_reg & ~wmask) | wdata;
        3'd4: fall_en_next   = (fall_en_reg & ~wmask) | wdata;
        3'd5: rise_pend_next = rise_pend_reg & ~wdata;
        3'd6: fall_pend_next = fall_pend_reg & ~wdata;
        3'd7: if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) err_next = 1'b0;
        default: ;
      endcase
    end
    // Edge sets are applied after the W1C clear so a colliding set survives.
    rise_pend_next = rise_pend_next | (rise_edge & rise_en_reg);
    fall_pend_next = fall_pend_next | (fall_edge & fall_en_reg);
    if (sel_hit && !mapped) err_next = 1'b1;
    dat_next = (sel_hit && !wbs.wbs_we_i && mapped) ? rd_data : '0;
    irq_next = {err_reg, |fall_pend_reg, |rise_pend_reg};
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      out_reg       <= '0;
      oeb_reg       <= OEB_RESET;
      rise_en_reg   <= '0;
      fall_en_reg   <= '0;
      rise_pend_reg <= '0;
      fall_pend_reg <= '0;
      err_reg       <= 1'b0;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      prev_reg      <= '0;
      ack_reg       <= 1'b0;
      dat_reg       <= '0;
      irq_reg       <= '0;
    end else begin
      out_reg       <= out_next;
      oeb_reg       <= oeb_next;
      rise_en_reg   <= rise_en_next;
      fall_en_reg   <= fall_en_next;
      rise_pend_reg <= rise_pend_next;
      fall_pend_reg <= fall_pend_next;
      err_reg       <= err_next;
      sync1_reg     <= io_in;
      sync2_reg     <= sync1_reg;
      prev_reg      <= sync2_reg;
      ack_reg       <= sel_hit;
      dat_reg       <= dat_next;
      irq_reg       <= irq_next;
    end
  end

  assign wbs.wbs_ack_o = ack_reg;
  assign wbs.wbs_dat_o = dat_reg;
  assign io_out        = out_reg;
  assign io_oeb        = oeb_reg;
  assign irq           = irq_reg;

endmodule

// File: tb/tb_wb_pad_ctrl.sv
// Bench for wb_pad_ctrl: register-map/pad-history model checked every cycle,
// plus directed transactions with literal expectations.
module tb_wb_pad_ctrl;
  localparam int          NPADS = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NPADS-1:0] io_in = '0;
  logic [NPADS-1:0] io_out, io_oeb;
  logic [2:0]       irq;

  int n_checks = 0;
  int n_fail   = 0;

  wb_pad_ctrl_if bif();

  wb_pad_ctrl #(.NPADS(NPADS), .ADDR_BASE(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wbs       (bif.slave),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Model: registers indexed by word offset; IN comes from a pad history where
  // hist[j] is the pad value sampled j+1 edges ago.
  logic [31:0] m_reg [0:7];
  logic [31:0] m_hist [0:2];
  logic        m_ack = 1'b0, m_rd_chk = 1'b0, m_ready = 1'b0;
  logic [31:0] m_dat = '0;
  logic [2:0]  m_irq = '0;

  always @(posedge clk) begin : model
    logic [31:0] rise, fall, ren, fen, bm, d;
    logic [7:0]  off;
    logic        sel;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_reg[1] = PMASK;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_ack = 0; m_dat = '0; m_irq = '0; m_rd_chk = 0; m_ready = 1;
    end else begin
      rise  = m_hist[1] & ~m_hist[2];
      fall  = ~m_hist[1] & m_hist[2];
      ren   = m_reg[3];
      fen   = m_reg[4];
      m_irq = {m_reg[7][0], |m_reg[6], |m_reg[5]};
      sel   = bif.wbs_cyc_i && bif.wbs_stb_i && !m_ack
              && (bif.wbs_adr_i[31:8] == BASE[31:8]);
      m_ack = sel; m_dat = '0; m_rd_chk = 0;
      if (sel) begin
        off = bif.wbs_adr_i[7:0];
        bm  = {{8{bif.wbs_sel_i[3]}}, {8{bif.wbs_sel_i[2]}}, {8{bif.wbs_sel_i[1]}}, {8{bif.wbs_sel_i[0]}}};
        d   = bif.wbs_dat_i & bm;
        if (off[1:0] != 2'b00 || off > 8'h1C) begin
          m_reg[7] = 32'd1;
          m_rd_chk = !bif.wbs_we_i;
        end else if (!bif.wbs_we_i) begin
          m_rd_chk = 1;
          m_dat = (off == 8'h08) ? m_hist[1] : m_reg[off[4:2]];
        end else begin
          case (off)
            8'h00, 8'h04, 8'h0C, 8'h10: m_reg[off[4:2]] = ((m_reg[off[4:2]] & ~bm) | d) & PMASK;
            8'h14, 8'h18:               m_reg[off[4:2]] = m_reg[off[4:2]] & ~d;
            8'h1C:                      m_reg[7] = m_reg[7] & ~(d & 32'd1);
            default: ;
          endcase
        end
      end
      m_reg[5] = m_reg[5] | (rise & ren);
      m_reg[6] = m_reg[6] | (fall & fen);
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = 32'(io_in);
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("ack", 32'(bif.wbs_ack_o), 32'(m_ack));
      chk("io_out", 32'(io_out), m_reg[0]);
      chk("io_oeb", 32'(io_oeb), m_reg[1]);
      chk("irq", 32'(irq), 32'(m_irq));
      if (!m_ack || m_rd_chk) chk("dat_o", bif.wbs_dat_o, m_ack ? m_dat : 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns one idle cycle after the ack (lat=10 means none).
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    bif.wbs_cyc_i = 1; bif.wbs_stb_i = 1; bif.wbs_we_i = we;
    bif.wbs_adr_i = adr; bif.wbs_dat_i = dat; bif.wbs_sel_i = sel;
    rdat = 32'hDEAD_BEEF;
    lat  = 10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.wbs_ack_o) begin
        rdat = bif.wbs_dat_o;
        lat  = i;
        break;
      end
    end
    bif.wbs_cyc_i = 0; bif.wbs_stb_i = 0; bif.wbs_we_i = 0;
    $display("%s adr=%08h wdat=%08h sel=%b rdat=%08h lat=%0d",
             we ? "WR" : "RD", adr, dat, sel, rdat, lat);
    step(1);
  endtask

  logic [31:0] rd;
  int          lat;
  logic [31:0] rst_exp [0:7];

  initial begin
    bif.wbs_cyc_i = 0; bif.wbs_stb_i = 0; bif.wbs_we_i = 0;
    bif.wbs_sel_i = '0; bif.wbs_adr_i = '0; bif.wbs_dat_i = '0;
    rst_exp = '{32'h0, 32'h0000_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    rst_n = 0;
    step(3);
    rst_n = 1;

    // Reset values at every offset, single-cycle ack one cycle after stb
    for (int i = 0; i < 8; i++) begin
      bus(0, BASE + 32'(4 * i), 32'h0, 4'hF, rd, lat);
      chk($sformatf("rst_rd_%02h", 4 * i), rd, rst_exp[i]);
      chk("rst_lat", 32'(lat), 32'd0);
    end

    // Byte-lane writes
    bus(1, BASE + 32'h00, 32'h0000_A5A5, 4'b0001, rd, lat);
    chk("out_lane0", 32'(io_out), 32'h0000_00A5);
    bus(1, BASE + 32'h00, 32'h0000_A5A5, 4'b0010, rd, lat);
    chk("out_lane1", 32'(io_out), 32'h0000_A5A5);
    bus(1, BASE + 32'h04, 32'h0, 4'hF, rd, lat);
    chk("oeb_zero", 32'(io_oeb), 32'h0);

    // Rising edge on pad 0: PEND at 3 edges, irq at 4
    bus(1, BASE + 32'h0C, 32'h0000_0009, 4'hF, rd, lat);
    io_in[0] = 1'b1;
    step(3);
    chk("irq0_early", 32'(irq[0]), 32'd0);
    step(1);
    chk("irq0_set", 32'(irq[0]), 32'd1);
    bus(0, BASE + 32'h08, 32'h0, 4'hF, rd, lat);
    chk("in_rd", rd, 32'h0000_0001);
    bus(0, BASE + 32'h14, 32'h0, 4'hF, rd, lat);
    chk("rpend_rd", rd, 32'h0000_0001);
    bus(1, BASE + 32'h14, 32'h0000_0001, 4'b0001, rd, lat);
    chk("irq0_clr", 32'(irq[0]), 32'd0);
    bus(0, BASE + 32'h14, 32'h0, 4'hF, rd, lat);
    chk("rpend_clr", rd, 32'h0);

    // Pad 3 edge lands in the same cycle as a W1C of bit 3: set wins
    io_in[3] = 1'b1;
    step(2);
    bus(1, BASE + 32'h14, 32'h0000_0008, 4'b0001, rd, lat);
    bus(0, BASE + 32'h14, 32'h0, 4'hF, rd, lat);
    chk("collide", rd, 32'h0000_0008);

    // Falling edge on pad 0
    bus(1, BASE + 32'h10, 32'h0000_0001, 4'hF, rd, lat);
    io_in[0] = 1'b0;
    step(4);
    chk("irq1_set", 32'(irq[1]), 32'd1);
    bus(0, BASE + 32'h18, 32'h0, 4'hF, rd, lat);
    chk("fpend_rd", rd, 32'h0000_0001);

    // Error accesses and out-of-window access
    bus(0, BASE + 32'h20, 32'h0, 4'hF, rd, lat);
    chk("unmapped_lat", 32'(lat), 32'd0);
    chk("unmapped_rd", rd, 32'h0);
    bus(1, BASE + 32'h06, 32'h0000_FFFF, 4'hF, rd, lat);
    chk("misalign_lat", 32'(lat), 32'd0);
    chk("misalign_drop", 32'(io_oeb), 32'h0);
    chk("irq2_set", 32'(irq[2]), 32'd1);
    bus(0, BASE + 32'h1C, 32'h0, 4'hF, rd, lat);
    chk("err_rd", rd, 32'h0000_0001);
    bus(0, BASE + 32'h100, 32'h0, 4'hF, rd, lat);
    chk("window_noack", 32'(lat), 32'd10);
    bus(1, BASE + 32'h1C, 32'h0000_0001, 4'b0001, rd, lat);
    chk("irq2_clr", 32'(irq[2]), 32'd0);

    // Reset in the cycle a write to OUT is selected
    bif.wbs_cyc_i = 1; bif.wbs_stb_i = 1; bif.wbs_we_i = 1;
    bif.wbs_adr_i = BASE; bif.wbs_dat_i = 32'h0000_FFFF; bif.wbs_sel_i = 4'hF;
    rst_n = 0;
    step(1);
    chk("rst_ack", 32'(bif.wbs_ack_o), 32'd0);
    chk("rst_out", 32'(io_out), 32'h0);
    chk("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
    chk("rst_irq", 32'(irq), 32'd0);
    bif.wbs_cyc_i = 0; bif.wbs_stb_i = 0; bif.wbs_we_i = 0;
    rst_n = 1;
    step(1);
    bus(0, BASE + 32'h00, 32'h0, 4'hF, rd, lat);
    chk("rst_out_rd", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
